instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Fetch stage directly upstream of the instruction memory: owns the PC, drives the memory
//  address, and registers {pc, instruction} into an IF/ID register for the decode stage.
//  - Handles decode back-pressure with a valid/ready handshake.
//  - Handles branch redirects and instruction-memory misses (fixed miss penalty, then retry).
// PARAMETERS
//  ADDR_W        32         PC / memory address width (byte address)
//  RESET_PC      32'h100    PC after reset (word 0x40, first program word)
//  MISS_PENALTY  4          stall cycles after a miss before retrying the same PC (0..15)
// PORTS
//  clk               in   1       rising-edge clock
//  reset             in   1       asynchronous, active-high reset
//  imem_address      out  ADDR_W  byte address to instruction memory; equals pc (combinational)
//  imem_instruction  in   32      instruction word returned for imem_address, same cycle
//  imem_miss         in   1       memory has no entry for imem_address this cycle
//  redirect_valid    in   1       taken branch/jump from execute; overrides all else
//  redirect_target   in   ADDR_W  new PC; bits [1:0] ignored (forced 00)
//  if_valid          out  1       IF/ID register holds a valid instruction
//  if_ready          in   1       decode accepts IF/ID contents this cycle
//  if_pc             out  ADDR_W  PC of the held instruction
//  if_instruction    out  32      held instruction word
//  perf_fetch_count  out  32      (FETCH_PERF_CNT_EN only) instructions loaded into IF/ID
//  perf_stall_count  out  32      (FETCH_PERF_CNT_EN only) cycles in MISS_WAIT or back-pressured
// BEHAVIOUR
//  - Reset (async): pc=RESET_PC, state=FETCH, miss counter=0, if_valid=0, if_pc=0, if_instruction=0.
//  - can_load = !if_valid || if_ready.
//  - States: FETCH, MISS_WAIT.
//  - FETCH & can_load & !imem_miss: IF/ID <= {pc, imem_instruction}, if_valid<=1, pc<=pc+4.
//    One-cycle latency: address to if_valid. One instruction per cycle when unstalled.
//  - FETCH & if_valid & !if_ready: hold pc and the IF/ID register unchanged; imem_miss ignored.
//  - FETCH & can_load & imem_miss:
//    - if_valid<=0; the held word is consumed by if_ready this cycle.
//    - pc unchanged.
//    - MISS_PENALTY>0: state<=MISS_WAIT, counter<=MISS_PENALTY-1.
//    - MISS_PENALTY=0: stay in FETCH and retry next cycle.
//  - MISS_WAIT: counter decrements each cycle; at 0, state<=FETCH and the same pc is retried.
//    if_valid stays 0 once consumed.
//  - redirect_valid (any state, highest priority):
//    - pc<={redirect_target[ADDR_W-1:2],2'b00}, if_valid<=0 (flush the wrong-path word).
//    - state<=FETCH, counter<=0.
//    - The current-cycle fetch is discarded even when if_ready=1.
//  - PC wrap: pc+4 wraps modulo 2^ADDR_W with no flag.
//  - Reset mid-miss or mid-stall: immediate return to reset values; no pending state survives.
//  - if_pc/if_instruction change only on a load; they are stable while if_valid & !if_ready.
// CONFIGURATION
//  - FETCH_PERF_CNT_EN defined:
//    - perf_fetch_count increments on each IF/ID load.
//    - perf_stall_count increments each cycle in MISS_WAIT, or in FETCH with if_valid & !if_ready.
//    - Both reset to 0 and wrap silently.
//  - FETCH_PERF_CNT_EN undefined: both ports and their counters are absent; all other behaviour is identical.
// STRUCTURE
//  - Package fetch_pkg:
//    - fetch_state_t enum {FETCH, MISS_WAIT}.
//    - INSTR_W=32, PC_STEP=4.
//    - NOP_WORD=32'h0 (IF/ID reset value).
//  - Sub-module fetch_miss_timer: loadable down-counter, 4 bits.
//    Inputs: load, load_value, clear. Output: done when the count is 0.
//  - The top holds the PC register, the state register, the next-PC mux and the IF/ID register.
// TESTING
//  1 Reset with if_ready=1, no misses: imem_address=0x100, if_valid=0.
//    First load gives if_pc=0x100, if_instruction=imem word; then 0x104, 0x108 on consecutive cycles.
//  2 Back-pressure: if_ready=0 for 3 cycles while if_valid=1 (if_pc=0x104).
//    if_pc, if_instruction and pc hold 3 cycles; 0x108 loads the cycle after if_ready=1.
//  3 Redirect: redirect_valid=1, target=0x12B while if_pc=0x108.
//    Next cycle if_valid=0 and imem_address=0x128; next load has if_pc=0x128.
//  4 Miss at pc=0x110, MISS_PENALTY=4: if_valid drops.
//    Exactly 4 cycles in MISS_WAIT, then pc 0x110 is retried and loads when imem_miss=0.
//  5 Redirect to 0x100 during the 2nd MISS_WAIT cycle: wait aborted; 0x100 fetched the next cycle.
//  6 FETCH_PERF_CNT_EN, 10 loads with 4 miss and 3 back-pressure cycles:
//    perf_fetch_count=10, perf_stall_count=7.
//    Assert reset mid-miss: all outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic {
    FETCH     = 1'b0,
    MISS_WAIT = 1'b1
  } fetch_state_t;

  localparam int          INSTR_W  = 32;
  localparam int          PC_STEP  = 4;
  localparam logic [31:0] NOP_WORD = 32'h0;

endpackage

// File: rtl/fetch_miss_timer.sv
// 4-bit loadable down-counter timing the instruction-memory miss penalty.
// Counts down to zero and rests there; done is high whenever the count is zero.
module fetch_miss_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       clear,
  output logic       done
);

  logic [3:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 4'd0;
    end else if (clear) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_value;
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign done = (count == 4'd0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, addresses instruction memory and fills the IF/ID register.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
//
// IF/ID handshake: a word moves to decode on a cycle where if_valid && if_ready;
// while if_valid && !if_ready the IF/ID contents and the PC are held unchanged.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC     = 'h100,
  parameter int                 MISS_PENALTY = 4
) (
  input  logic                clk,
  input  logic                reset,
  output logic [ADDR_W-1:0]   imem_address,
  input  logic [INSTR_W-1:0]  imem_instruction,
  input  logic                imem_miss,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_target,
  output logic                if_valid,
  input  logic                if_ready,
  output logic [ADDR_W-1:0]   if_pc,
  output logic [INSTR_W-1:0]  if_instruction,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]         perf_fetch_count,
  output logic [31:0]         perf_stall_count,
`endif
  output fetch_state_t        dbgState
);

  localparam logic [3:0] MISS_LOAD = (MISS_PENALTY > 0) ? 4'(MISS_PENALTY - 1) : 4'd0;

  fetch_state_t       state, nextState;
  logic [ADDR_W-1:0]  pc, pcNext;
  logic               canLoad, doLoad, doFlush, timerLoad, timerClear, timerDone;

  assign canLoad      = !if_valid || if_ready;
  assign imem_address = pc;
  assign dbgState     = state;

  fetch_miss_timer u_missTimer (
    .clk        (clk),
    .reset      (reset),
    .load       (timerLoad),
    .load_value (MISS_LOAD),
    .clear      (timerClear),
    .done       (timerDone)
  );

  always_comb begin
    nextState  = state;
    pcNext     = pc;
    doLoad     = 1'b0;
    doFlush    = 1'b0;
    timerLoad  = 1'b0;
    timerClear = 1'b0;
    if (redirect_valid) begin
      // Redirect wins over everything, including a fetch decode would accept this cycle.
      pcNext     = {redirect_target[ADDR_W-1:2], 2'b00};
      doFlush    = 1'b1;
      nextState  = FETCH;
      timerClear = 1'b1;
    end else begin
      case (state)
        FETCH: begin
          if (canLoad) begin
            if (!imem_miss) begin
              doLoad = 1'b1;
              pcNext = pc + ADDR_W'(PC_STEP);
            end else begin
              doFlush = 1'b1;
              if (MISS_PENALTY > 0) begin
                nextState = MISS_WAIT;
                timerLoad = 1'b1;
              end
            end
          end
        end
        MISS_WAIT: begin
          if (timerDone) nextState = FETCH;
        end
        default: nextState = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= nextState;
      pc    <= pcNext;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_valid       <= 1'b0;
      if_pc          <= '0;
      if_instruction <= NOP_WORD;
    end else if (doLoad) begin
      if_valid       <= 1'b1;
      if_pc          <= pc;
      if_instruction <= imem_instruction;
    end else if (doFlush) begin
      if_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch_count <= 32'd0;
      perf_stall_count <= 32'd0;
    end else begin
      if (doLoad) perf_fetch_count <= perf_fetch_count + 32'd1;
      if ((state == MISS_WAIT) || ((state == FETCH) && if_valid && !if_ready))
        perf_stall_count <= perf_stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: sequential fetch, back-pressure, redirect,
// miss penalty, redirect during a miss, async reset mid-miss, PC wrap and perf counters.
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  imem_address;
  logic [31:0]  imem_instruction;
  logic         imem_miss;
  logic         redirect_valid;
  logic [31:0]  redirect_target;
  logic         if_valid;
  logic         if_ready;
  logic [31:0]  if_pc;
  logic [31:0]  if_instruction;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]  perf_fetch_count;
  logic [31:0]  perf_stall_count;
`endif
  fetch_state_t dbgState;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  // instruction memory model: word content derived from the address
  always_comb imem_instruction = 32'hC0DE_0000 ^ imem_address;

  instruction_fetch_unit dut (
    .clk              (clk),
    .reset            (reset),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .imem_miss        (imem_miss),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .if_valid         (if_valid),
    .if_ready         (if_ready),
    .if_pc            (if_pc),
    .if_instruction   (if_instruction),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_count (perf_fetch_count),
    .perf_stall_count (perf_stall_count),
`endif
    .dbgState         (dbgState)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_if(input string tag, input logic v, input logic [31:0] pcv,
                          input logic [31:0] addr);
    check({tag, "_valid"}, 32'(if_valid), 32'(v));
    check({tag, "_pc"}, if_pc, pcv);
    if (v) check({tag, "_instr"}, if_instruction, 32'hC0DE_0000 ^ pcv);
    check({tag, "_addr"}, imem_address, addr);
  endtask

  initial begin
    reset = 1'b1; if_ready = 1'b1; imem_miss = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'h0;
    #3;
    check("rst_addr", imem_address, 32'h100);
    check("rst_valid", 32'(if_valid), 32'h0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_instr", if_instruction, 32'h0);
    #9 reset = 1'b0;

    // 1: sequential fetch
    step(); check_if("seq0", 1'b1, 32'h100, 32'h104);
    check("seq0_word", if_instruction, 32'hC0DE_0100);
    step(); check_if("seq1", 1'b1, 32'h104, 32'h108);

    // 2: back-pressure for 3 cycles
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); check_if("bp_hold", 1'b1, 32'h104, 32'h108);
    end
    if_ready = 1'b1;
    step(); check_if("bp_release", 1'b1, 32'h108, 32'h10C);

    // 3: redirect with misaligned target
    redirect_valid = 1'b1; redirect_target = 32'h12B;
    step(); check("redir_valid", 32'(if_valid), 32'h0);
    check("redir_addr", imem_address, 32'h128);
    redirect_valid = 1'b0;
    step(); check_if("redir_load", 1'b1, 32'h128, 32'h12C);

    // 4: miss at 0x110 while a valid word is being consumed
    redirect_valid = 1'b1; redirect_target = 32'h10C;
    step(); redirect_valid = 1'b0;
    step(); check_if("pre_miss", 1'b1, 32'h10C, 32'h110);
    imem_miss = 1'b1;
    step(); imem_miss = 1'b0;
    check("miss_drop", 32'(if_valid), 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      check("miss_wait_state", 32'(dbgState), 32'(MISS_WAIT));
      check("miss_wait_addr", imem_address, 32'h110);
    end
    step(); check("miss_retry_state", 32'(dbgState), 32'(FETCH));
    check("miss_retry_valid", 32'(if_valid), 32'h0);
    step(); check_if("miss_load", 1'b1, 32'h110, 32'h114);

    // 5: redirect during the 2nd MISS_WAIT cycle
    imem_miss = 1'b1;
    step(); imem_miss = 1'b0;
    check("m2_state1", 32'(dbgState), 32'(MISS_WAIT));
    step(); check("m2_state2", 32'(dbgState), 32'(MISS_WAIT));
    redirect_valid = 1'b1; redirect_target = 32'h100;
    step(); redirect_valid = 1'b0;
    check("m2_abort_state", 32'(dbgState), 32'(FETCH));
    check_if("m2_abort", 1'b0, 32'h110, 32'h100);
    step(); check_if("m2_load", 1'b1, 32'h100, 32'h104);

    // async reset mid-miss
    imem_miss = 1'b1;
    step(); imem_miss = 1'b0;
    check("rm_state", 32'(dbgState), 32'(MISS_WAIT));
    #2 reset = 1'b1;
    #1;
    check("rm_addr", imem_address, 32'h100);
    check("rm_valid", 32'(if_valid), 32'h0);
    check("rm_pc", if_pc, 32'h0);
    check("rm_instr", if_instruction, 32'h0);
    check("rm_state_fetch", 32'(dbgState), 32'(FETCH));
`ifdef FETCH_PERF_CNT_EN
    check("rm_perf_fetch", perf_fetch_count, 32'd0);
    check("rm_perf_stall", perf_stall_count, 32'd0);
`endif
    #3 reset = 1'b0;

    // 6: 10 loads, 3 back-pressure cycles, 4 miss-wait cycles
    for (int i = 0; i < 4; i++) step();
    check_if("pf_seq", 1'b1, 32'h10C, 32'h110);
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    if_ready = 1'b1;
    step(); check_if("pf_bp", 1'b1, 32'h110, 32'h114);
    imem_miss = 1'b1;
    step(); imem_miss = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("pf_after_wait", 32'(dbgState), 32'(FETCH));
    for (int i = 0; i < 5; i++) step();
    check_if("pf_end", 1'b1, 32'h124, 32'h128);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetch", perf_fetch_count, 32'd10);
    check("perf_stall", perf_stall_count, 32'd7);
`endif

    // PC wrap
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFF;
    step(); redirect_valid = 1'b0;
    check("wrap_addr0", imem_address, 32'hFFFF_FFFC);
    step(); check_if("wrap", 1'b1, 32'hFFFF_FFFC, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
